// File: rtl/rst_tick_seq_pkg.sv
// rst_tick_seq_pkg -- shared state encoding, default parameter values and a
// small helper used to size the sequencer's shared cycle counter.
package rst_tick_seq_pkg;

  // Sequencer states. Every state except ST_RUN reports seq_busy.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SWRST   = 2'd3
  } seq_state_e;

  // Default parameter values for rst_tick_seq.
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_HOLD_CYCLES = 5;
  localparam int DEF_STAGGER     = 16;
  localparam int DEF_DIV_W       = 16;

  // Larger of two integers, used at elaboration time only.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_tick_seq_tick_div.sv
// tick_div -- one per-channel clock-enable divider.
// While clr is high the counter and tick are held at zero. Once clr drops,
// tick pulses on the edge that completes each period of div+1 cycles, so the
// first pulse lands div cycles after the first edge with clr low, and div=0
// yields a tick on every cycle. The divide value is captured at the first
// edge of every period (the release edge and the edge after each wrap), so a
// change in the middle of a period only affects the following period.
module tick_div
  import rst_tick_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             ref_clk,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_q;
  logic             r_tick;
  logic [DIV_W-1:0] w_div_cur;

  // Period length in force: fresh sample at period start, held value otherwise.
  always_comb begin
    w_div_cur = r_div_q;
    if (r_cnt == '0) begin
      w_div_cur = div;
    end
  end

  // Count within the period; wrap and pulse when the count reaches the divide value.
  always_ff @(posedge ref_clk) begin
    if (clr) begin
      r_cnt   <= '0;
      r_div_q <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_div_q <= w_div_cur;
      if (r_cnt == w_div_cur) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + DIV_W'(1);
        r_tick <= 1'b0;
      end
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/rst_tick_seq.sv
// rst_tick_seq -- staggered multi-channel reset sequencer with optional
// per-channel tick generators.
//
// After rst drops, all channel resets stay asserted for HOLD_CYCLES cycles,
// then channel 0 is released, followed by each higher channel STAGGER cycles
// apart. One cycle after the last release the sequencer enters RUN and raises
// ready. In RUN a single-cycle sw_rst_req re-asserts every channel reset,
// holds it for HOLD_CYCLES cycles and replays the staggered release.
//
// Build option: define RST_TICK_SEQ_TICK_EN to instantiate one tick_div per
// channel. Without it, tick is tied low, div_val is ignored and no divider
// hardware exists; the reset sequencing is identical in both builds.
//
// o_dbg_state exposes the current sequencer state for observation.
module rst_tick_seq
  import rst_tick_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int DIV_W       = DEF_DIV_W
) (
  input  logic                    ref_clk,
  input  logic                    rst,
  input  logic                    sw_rst_req,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  output logic [NUM_CH-1:0]       rst_out,
  output logic [NUM_CH-1:0]       tick,
  output logic                    ready,
  output logic                    seq_busy,
  output seq_state_e              o_dbg_state
);

  // The shared counter must reach HOLD_CYCLES (hold state) and STAGGER-1.
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGGER) + 1);

  // Reset vector right after the first release: every channel but 0 held.
  localparam logic [NUM_CH-1:0] FIRST_REL = ~NUM_CH'(1);

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [NUM_CH-1:0] r_rst_out;
  logic [NUM_CH-1:0] w_rst_out_nxt;

  // Handshake note: sw_rst_req is a plain single-cycle request with no ready
  // or acknowledge; it is acted on only when sampled high while in RUN and is
  // silently dropped in every other state. rst overrides everything.

  // Next-state, next-count and next reset vector for the sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rst_out_nxt = r_rst_out;
    case (r_state)
      // The counter already holds the number of rst=0 edges seen, including
      // the first one, so the release happens when it equals HOLD_CYCLES.
      ST_HOLD: begin
        w_rst_out_nxt = '1;
        if (r_cnt == CNT_W'(HOLD_CYCLES)) begin
          w_state_nxt   = ST_RELEASE;
          w_cnt_nxt     = '0;
          w_rst_out_nxt = FIRST_REL;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      // Channels release in ascending order, so shifting the vector left
      // releases exactly the next channel. An all-zero vector means the
      // last channel went down on the previous edge.
      ST_RELEASE: begin
        if (r_rst_out == '0) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(STAGGER - 1)) begin
          w_cnt_nxt     = '0;
          w_rst_out_nxt = r_rst_out << 1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (sw_rst_req) begin
          w_state_nxt   = ST_SWRST;
          w_cnt_nxt     = '0;
          w_rst_out_nxt = '1;
        end
      end
      // Entered on the request edge with the count at zero, so the release
      // edge is the one where the count has reached HOLD_CYCLES-1.
      ST_SWRST: begin
        w_rst_out_nxt = '1;
        if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          w_state_nxt   = ST_RELEASE;
          w_cnt_nxt     = '0;
          w_rst_out_nxt = FIRST_REL;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_HOLD;
        w_cnt_nxt     = '0;
        w_rst_out_nxt = '1;
      end
    endcase
  end

  // Sequencer registers; rst restarts the whole sequence from HOLD.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      r_state   <= ST_HOLD;
      r_cnt     <= '0;
      r_rst_out <= '1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rst_out <= w_rst_out_nxt;
    end
  end

  assign rst_out     = r_rst_out;
  assign ready       = (r_state == ST_RUN);
  assign seq_busy    = (r_state != ST_RUN);
  assign o_dbg_state = r_state;

`ifdef RST_TICK_SEQ_TICK_EN
  // Dividers are cleared from the reset value the channel will hold after
  // this edge, so a tick can never coincide with an asserted channel reset
  // and counting starts on the very edge a channel is released.
  logic [NUM_CH-1:0] w_clr;
  assign w_clr = w_rst_out_nxt | {NUM_CH{rst}};

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_div
    tick_div #(
      .DIV_W (DIV_W)
    ) u_tick_div (
      .ref_clk (ref_clk),
      .clr     (w_clr[gi]),
      .div     (div_val[gi*DIV_W +: DIV_W]),
      .tick    (tick[gi])
    );
  end
`else
  // No dividers in this build: ticks are tied off and div_val is ignored.
  logic w_div_unused;
  assign w_div_unused = ^div_val;
  assign tick         = '0;
`endif

endmodule

// File: doc/rst_tick_seq.md
RST_TICK_SEQ -- requirements
Module: rst_tick_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of reset/tick channels (1..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 5, global reset hold length in ref_clk cycles (>=1).
REQ-003 SHALL have parameter STAGGER, default 16, cycles between successive channel releases (>=1).
REQ-004 SHALL have parameter DIV_W, default 16, width of each per-channel divide value.
REQ-005 SHALL have port ref_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port sw_rst_req  input  1  single-cycle soft-reset request.
REQ-008 SHALL have port div_val  input  NUM_CH*DIV_W  per-channel tick divide value; channel i in bits [i*DIV_W +: DIV_W].
REQ-009 SHALL have port rst_out  output  NUM_CH  per-channel active-high reset.
REQ-010 SHALL have port tick  output  NUM_CH  per-channel single-cycle clock-enable pulse.
REQ-011 SHALL have port ready  output  1  high when all channels are released.
REQ-012 SHALL have port seq_busy  output  1  high in every state except RUN.

Function
REQ-013 SHALL implement FSM states HOLD, RELEASE, RUN, SWRST.
REQ-014 HOLD: count consecutive cycles with rst=0; after HOLD_CYCLES such cycles, go to RELEASE.
REQ-015 rst_out[0] SHALL fall exactly HOLD_CYCLES cycles after the first edge that samples rst=0.
REQ-016 rst_out[i] SHALL fall exactly i*STAGGER cycles after rst_out[0]; channels release in ascending order only.
REQ-017 ready SHALL rise one cycle after rst_out[NUM_CH-1] falls; FSM enters RUN on the same edge.
REQ-018 RUN: a sw_rst_req pulse SHALL re-assert all rst_out and drop ready on the next edge; enter SWRST.
REQ-019 SWRST: hold all rst_out high for HOLD_CYCLES cycles, then enter RELEASE with the same timing as REQ-015/016.
REQ-020 sw_rst_req SHALL be ignored in HOLD, RELEASE and SWRST.
REQ-021 Per-channel tick counter SHALL run only while rst_out[i]=0 and SHALL be cleared while rst_out[i]=1.
REQ-022 tick[i] SHALL pulse once every div_val[i]+1 cycles; div_val[i]=0 gives tick high every cycle.
REQ-023 First tick[i] SHALL occur div_val[i] cycles after rst_out[i] falls.
REQ-024 div_val[i] SHALL be sampled only at counter wrap and at release; mid-period changes take effect next period.
REQ-025 Counters SHALL be DIV_W bits wide; no overflow is possible because wrap occurs at div_val.

Reset
REQ-026 rst=1 SHALL, on any edge and in any state, force HOLD, clear counters, and drive rst_out all-ones, tick=0, ready=0, seq_busy=1.
REQ-027 rst asserted mid-RELEASE or mid-SWRST SHALL restart the full sequence from HOLD.
REQ-028 rst and sw_rst_req high on the same edge: rst SHALL win.

Configuration
REQ-029 Macro RST_TICK_SEQ_TICK_EN defined: tick generators SHALL be present per REQ-021..025.
REQ-030 Macro undefined: tick SHALL be constant 0, div_val SHALL be unused, and no divider logic SHALL be synthesised; all sequencing behaviour SHALL be unchanged.

Structure
REQ-031 Package rst_tick_seq_pkg SHALL hold the FSM state encoding and default parameter constants.
REQ-032 Per-channel divider SHALL be sub-module tick_div (inputs ref_clk, clr, div; output tick), instantiated NUM_CH times.

Verification
REQ-033 Defaults; rst high 5 cycles then low -> rst_out[0..3] fall at cycles 5, 21, 37, 53 after the first rst=0 edge; ready rises at 54.
REQ-034 In RUN, pulse sw_rst_req -> rst_out=4'hF and ready=0 on the next edge; rst_out[0] falls 5 cycles later, then sequence repeats.
REQ-035 div_val channel 1 = 3 -> tick[1] high every 4th cycle, first pulse 3 cycles after rst_out[1] falls; channel 2 = 0 -> tick[2] continuously high.
REQ-036 Assert rst at cycle 30 (mid-RELEASE) -> all rst_out high next edge, tick all 0; release timing restarts from the rst=0 edge.
REQ-037 sw_rst_req pulsed during RELEASE -> ignored, release timing unchanged; rst and sw_rst_req together in RUN -> FSM in HOLD.
REQ-038 Build without RST_TICK_SEQ_TICK_EN, repeat REQ-033 -> identical rst_out/ready timing, tick constant 0.
